// File: rtl/multi_countdown_pkg.sv
// Shared types and helpers for the multi_countdown channel bank.
// Provides the per-channel state encoding, the BCD width and a binary-to-BCD helper.
// Purely declarative: no logic or timing of its own.
package multi_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } ch_state_e;

    localparam int BCD_DIGITS = 3;
    localparam int BCD_W      = BCD_DIGITS * 4;

    // Double-dabble conversion to three BCD digits (hundreds, tens, units).
    // Anything that cannot be shown on three digits saturates to 999.
    function automatic logic [BCD_W-1:0] bin_to_bcd(input logic [31:0] bin);
        logic [9:0]       b;
        logic [BCD_W-1:0] bcd;
        if (bin >= 32'd1000) begin
            return 12'h999;
        end
        b   = bin[9:0];
        bcd = '0;
        for (int i = 9; i >= 0; i--) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) begin
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[BCD_W-2:0], b[i]};
        end
        return bcd;
    endfunction

endpackage

// File: rtl/multi_countdown_if.sv
// Load request bus into the countdown bank: channel select, start value, valid/ready.
// Latency: none, wires only.
// Backpressure: the slave lowers load_ready; the master must hold its request until accepted.
interface multi_countdown_if #(
    parameter int CH_BITS    = 2,
    parameter int COUNT_BITS = 8
) ();
    logic                  load_valid;
    logic                  load_ready;
    logic [CH_BITS-1:0]    load_ch;
    logic [COUNT_BITS-1:0] load_value;

    modport master (output load_valid, output load_ch, output load_value, input load_ready);
    modport slave  (input load_valid, input load_ch, input load_value, output load_ready);
endinterface

// File: rtl/multi_countdown_channel.sv
// One countdown channel: IDLE/RUN/HOLD/DONE FSM, down-counter, reload register, timeout pulse flop.
// Latency: a load or tick at one edge is visible on count/running/expired/timeout_pulse right after it.
// Backpressure: none; a load request is always applied and overrides a same-cycle tick.
// Ports: clk/rst, tick/enable/pause controls, load strobe + load_value in; count, running,
//        expired, timeout_pulse out.
module multi_countdown_channel
    import multi_countdown_pkg::*;
#(
    parameter int COUNT_BITS  = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  pause,
    input  logic                  load,
    input  logic [COUNT_BITS-1:0] load_value,
    output logic                  running,
    output logic                  expired,
    output logic                  timeout_pulse,
    output logic [COUNT_BITS-1:0] count
);

    ch_state_e             state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [COUNT_BITS-1:0] reload_q, reload_d;
    logic                  pulse_q, pulse_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pulse_d  = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            // A zero start value counts as an immediate expiry.
            if (load_value == '0) begin
                state_d = DONE;
                pulse_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (enable && tick) begin
                        if (count_q == COUNT_BITS'(1)) begin
                            pulse_d = 1'b1;
                            if (AUTO_RELOAD && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - COUNT_BITS'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pulse_q  <= pulse_d;
        end
    end

    assign running       = (state_q == RUN);
    assign expired       = (state_q == DONE);
    assign timeout_pulse = pulse_q;
    assign count         = count_q;

endmodule

// File: rtl/multi_countdown.sv
// N-channel down-counter bank (phase timers): load decode, load handshake, optional BCD output registers.
// Latency: load/tick effects 1 clk after the edge; count_bcd 1 further clk (MULTI_COUNTDOWN_BCD_EN).
// Backpressure: load_ready drops for one cycle after each accept, so loads sustain one per 2 cycles.
// Ports: clk, rst (async, active high), tick, enable, ld (load bus, slave), pause[NUM_CH];
//        running, expired, timeout_pulse [NUM_CH], count [NUM_CH*COUNT_BITS], count_bcd [NUM_CH*12].
// Build option: define MULTI_COUNTDOWN_BCD_EN for BCD counts; otherwise count_bcd is tied to zero.
module multi_countdown
    import multi_countdown_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                COUNT_BITS  = 8,
    parameter int                CH_BITS     = 2,
    parameter logic [NUM_CH-1:0] AUTO_RELOAD = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         enable,
    multi_countdown_if.slave             ld,
    input  logic [NUM_CH-1:0]            pause,
    output logic [NUM_CH-1:0]            running,
    output logic [NUM_CH-1:0]            expired,
    output logic [NUM_CH-1:0]            timeout_pulse,
    output logic [NUM_CH*COUNT_BITS-1:0] count,
    output logic [NUM_CH*BCD_W-1:0]      count_bcd
);

    logic load_ready_q, load_ready_d;
    logic load_accept;

    assign load_accept = ld.load_valid & load_ready_q;

    always_comb begin
        load_ready_d = ~load_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready_q <= 1'b1;
        end else begin
            load_ready_q <= load_ready_d;
        end
    end

    assign ld.load_ready = load_ready_q;

    // A channel number with no matching channel is still accepted; no channel sees the load.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ch_load;
        assign ch_load = load_accept && (ld.load_ch == CH_BITS'(i));

        multi_countdown_channel #(
            .COUNT_BITS  (COUNT_BITS),
            .AUTO_RELOAD (AUTO_RELOAD[i])
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .enable        (enable),
            .pause         (pause[i]),
            .load          (ch_load),
            .load_value    (ld.load_value),
            .running       (running[i]),
            .expired       (expired[i]),
            .timeout_pulse (timeout_pulse[i]),
            .count         (count[i*COUNT_BITS +: COUNT_BITS])
        );
    end

`ifdef MULTI_COUNTDOWN_BCD_EN
    logic [NUM_CH*BCD_W-1:0] bcd_q, bcd_d;

    always_comb begin
        bcd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bcd_d[i*BCD_W +: BCD_W] = bin_to_bcd(32'(count[i*COUNT_BITS +: COUNT_BITS]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign count_bcd = bcd_q;
`else
    assign count_bcd = '0;
`endif

endmodule

// File: tb/tb_multi_countdown.sv
// Directed bench for multi_countdown: reset, load handshake, countdown, auto-reload, pause, enable.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_multi_countdown;

    localparam int NUM_CH     = 4;
    localparam int COUNT_BITS = 8;
    localparam int CH_BITS    = 3;

    logic                         clk    = 1'b0;
    logic                         rst    = 1'b1;
    logic                         tick   = 1'b0;
    logic                         enable = 1'b0;
    logic [NUM_CH-1:0]            pause  = '0;
    logic [NUM_CH-1:0]            running;
    logic [NUM_CH-1:0]            expired;
    logic [NUM_CH-1:0]            timeout_pulse;
    logic [NUM_CH*COUNT_BITS-1:0] count;
    logic [NUM_CH*12-1:0]         count_bcd;

    int total = 0;
    int bad   = 0;

    multi_countdown_if #(.CH_BITS(CH_BITS), .COUNT_BITS(COUNT_BITS)) ld ();

    multi_countdown #(
        .NUM_CH      (NUM_CH),
        .COUNT_BITS  (COUNT_BITS),
        .CH_BITS     (CH_BITS),
        .AUTO_RELOAD (4'b0001)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .enable        (enable),
        .ld            (ld),
        .pause         (pause),
        .running       (running),
        .expired       (expired),
        .timeout_pulse (timeout_pulse),
        .count         (count),
        .count_bcd     (count_bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [COUNT_BITS-1:0] cnt(input int i);
        return count[i*COUNT_BITS +: COUNT_BITS];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic load(input logic [CH_BITS-1:0] ch, input logic [COUNT_BITS-1:0] val);
        ld.load_valid = 1'b1;
        ld.load_ch    = ch;
        ld.load_value = val;
        step();
        ld.load_valid = 1'b0;
    endtask

    initial begin
        ld.load_valid = 1'b0;
        ld.load_ch    = '0;
        ld.load_value = '0;
        repeat (2) step();

        // Reset state
        chk("rst_ready",   ld.load_ready, 1);
        chk("rst_count",   count, 0);
        chk("rst_running", running, 0);
        chk("rst_expired", expired, 0);
        chk("rst_pulse",   timeout_pulse, 0);
        chk("rst_bcd",     count_bcd, 0);
        rst    = 1'b0;
        enable = 1'b1;
        step();

        // Plain countdown on ch1 from 3, tick every 4 clk
        load(1, 3);
        chk("a_load_cnt",   cnt(1), 3);
        chk("a_running",    running, 4'b0010);
        chk("a_ready_drop", ld.load_ready, 0);
        step();
        chk("a_ready_back", ld.load_ready, 1);
        pulse_tick();
        chk("a_t1", cnt(1), 2);
        repeat (3) step();
        pulse_tick();
        chk("a_t2",       cnt(1), 1);
        chk("a_t2_pulse", timeout_pulse, 0);
        repeat (3) step();
        pulse_tick();
        chk("a_t3",       cnt(1), 0);
        chk("a_pulse",    timeout_pulse, 4'b0010);
        chk("a_expired",  expired, 4'b0010);
        chk("a_stopped",  running, 4'b0000);
        step();
        chk("a_pulse_once", timeout_pulse, 0);
        chk("a_expired_lv", expired, 4'b0010);
        pulse_tick();
        chk("a_nowrap", cnt(1), 0);

        // Auto-reload on ch0 from 2
        load(0, 2);
        chk("b_load_cnt", cnt(0), 2);
        step();
        pulse_tick();
        chk("b_t1", cnt(0), 1);
        pulse_tick();
        chk("b_reload",     cnt(0), 2);
        chk("b_pulse",      timeout_pulse, 4'b0001);
        chk("b_no_expired", expired, 4'b0010);
        chk("b_running",    running, 4'b0001);
        pulse_tick();
        chk("b_t3",       cnt(0), 1);
        chk("b_t3_pulse", timeout_pulse, 0);
        pulse_tick();
        chk("b_reload2", cnt(0), 2);
        chk("b_pulse2",  timeout_pulse, 4'b0001);

        // Load 0 on ch0: immediate DONE with a pulse
        load(0, 0);
        chk("z_count",   cnt(0), 0);
        chk("z_pulse",   timeout_pulse, 4'b0001);
        chk("z_expired", expired, 4'b0011);
        step();
        chk("z_pulse_off", timeout_pulse, 0);

        // Pause on ch2, including pause and tick in the same cycle
        load(2, 5);
        step();
        pause = 4'b0100;
        tick  = 1'b1;
        step();
        tick  = 1'b0;
        chk("c_pause_tick", cnt(2), 5);
        chk("c_hold",       running, 4'b0000);
        pulse_tick();
        pulse_tick();
        chk("c_held", cnt(2), 5);
        pause = '0;
        step();
        chk("c_run_again", running, 4'b0100);
        pulse_tick();
        chk("c_resume", cnt(2), 4);

        // load_valid held 4 cycles: only the 1st and 3rd are accepted
        ld.load_valid = 1'b1;
        ld.load_ch    = 3'd3;
        ld.load_value = 8'd7;
        step();
        chk("d1_cnt",   cnt(3), 7);
        chk("d1_ready", ld.load_ready, 0);
        ld.load_value = 8'd9;
        step();
        chk("d2_cnt",   cnt(3), 7);
        chk("d2_ready", ld.load_ready, 1);
        ld.load_value = 8'd11;
        step();
        chk("d3_cnt",   cnt(3), 11);
        chk("d3_ready", ld.load_ready, 0);
        ld.load_value = 8'd13;
        step();
        chk("d4_cnt",   cnt(3), 11);
        chk("d4_ready", ld.load_ready, 1);
        ld.load_valid = 1'b0;

        // Load and tick together: load wins on ch3, ch2 still decrements
        ld.load_valid = 1'b1;
        ld.load_ch    = 3'd3;
        ld.load_value = 8'd20;
        tick          = 1'b1;
        step();
        ld.load_valid = 1'b0;
        tick          = 1'b0;
        chk("e_load_wins", cnt(3), 20);
        chk("e_other_dec", cnt(2), 3);
        step();

        // Out-of-range channel: accepted, nothing changes
        load(5, 99);
        chk("f_accepted", ld.load_ready, 0);
        chk("f_counts",   count, 32'h1403_0000);
        chk("f_running",  running, 4'b1100);
        step();

        // enable=0 freezes counts, loads still accepted
        enable = 1'b0;
        pulse_tick();
        chk("g_freeze2", cnt(2), 3);
        chk("g_freeze3", cnt(3), 20);
        load(1, 255);
        chk("g_load",    cnt(1), 255);
        chk("g_running", running, 4'b1110);
`ifdef MULTI_COUNTDOWN_BCD_EN
        chk("h_bcd_lag", count_bcd[12 +: 12], 12'h000);
        step();
        chk("h_bcd_255", count_bcd[12 +: 12], 12'h255);
        chk("h_bcd_ch3", count_bcd[36 +: 12], 12'h020);
`else
        step();
        chk("h_bcd_off", count_bcd, 0);
`endif

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b1;
        #1;
        chk("r_count",   count, 0);
        chk("r_ready",   ld.load_ready, 1);
        chk("r_running", running, 0);
        chk("r_expired", expired, 0);
        chk("r_pulse",   timeout_pulse, 0);
        chk("r_bcd",     count_bcd, 0);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
